// File: rtl/receiver_pkg.sv
// Shared UART definitions: receive FSM state encoding and frame geometry.
package receiver_pkg;

   localparam int FRAME_BITS = 10;
   localparam int DATA_BITS  = 8;

   typedef enum logic [2:0] {
      IDLE_RX,
      START_RX,
      DATA_RX,
      STOP_RX,
      BREAK_RX
   } rx_state_e;

endpackage

// File: rtl/receiver_if.sv
// Serial input and parallel byte output bundle of the UART receive stage.
interface receiver_if;
   import receiver_pkg::*;

   logic                 rx;
   logic [DATA_BITS-1:0] data;
   logic                 valid;
   logic                 frame_error;
   logic                 busy;

   modport slave (
      input  rx,
      output data, valid, frame_error, busy
   );

   modport master (
      output rx,
      input  data, valid, frame_error, busy
   );

endinterface

// File: rtl/receiver_oversample_tick.sv
// Oversample tick generator: one-clk tick every TICK_DIV clks while enabled.
module oversample_tick #(
   parameter int TICK_DIV = 27
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q;

   // Holding the counter at zero while disabled aligns the sampling phase to the start edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (!en || cnt_q == LAST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/receiver.sv
// UART 8N1 receiver: 2-flop input sync, 16x oversampling, mid-bit sampling, break recovery.
module receiver
   import receiver_pkg::*;
#(
   parameter int TICK_DIV   = 27,
   parameter int OVERSAMPLE = 16
) (
   input  logic           clk,
   input  logic           rst,
   receiver_if.slave      bus
);

   localparam logic [3:0] START_MID   = 4'(OVERSAMPLE / 2 - 1);
   localparam logic [3:0] LAST_SAMPLE = 4'(OVERSAMPLE - 1);

   rx_state_e            state_q;
   logic                 rx_meta_q, rx_s_q;
   logic [3:0]           sample_cnt_q;
   logic [2:0]           bit_cnt_q;
   logic [DATA_BITS-1:0] shift_q, data_q;
   logic                 valid_q, ferr_q, busy_q;
   logic                 tick;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= bus.rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   oversample_tick #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (state_q != IDLE_RX),
      .tick (tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE_RX;
         sample_cnt_q <= '0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         data_q       <= '0;
         valid_q      <= 1'b0;
         ferr_q       <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         case (state_q)
            IDLE_RX: begin
               sample_cnt_q <= '0;
               bit_cnt_q    <= '0;
               if (!rx_s_q) begin
                  state_q <= START_RX;
                  busy_q  <= 1'b1;
               end
            end
            START_RX: if (tick) begin
               if (sample_cnt_q == START_MID) begin
                  sample_cnt_q <= '0;
                  if (rx_s_q) begin
                     state_q <= IDLE_RX;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= DATA_RX;
                  end
               end else begin
                  sample_cnt_q <= sample_cnt_q + 1'b1;
               end
            end
            DATA_RX: if (tick) begin
               if (sample_cnt_q == LAST_SAMPLE) begin
                  sample_cnt_q <= '0;
                  shift_q      <= {rx_s_q, shift_q[DATA_BITS-1:1]};
                  bit_cnt_q    <= bit_cnt_q + 1'b1;
                  if (bit_cnt_q == 3'd7) state_q <= STOP_RX;
               end else begin
                  sample_cnt_q <= sample_cnt_q + 1'b1;
               end
            end
            STOP_RX: if (tick) begin
               if (sample_cnt_q == LAST_SAMPLE) begin
                  sample_cnt_q <= '0;
                  if (rx_s_q) begin
                     data_q  <= shift_q;
                     valid_q <= 1'b1;
                     state_q <= IDLE_RX;
                     busy_q  <= 1'b0;
                  end else begin
                     ferr_q  <= 1'b1;
                     state_q <= BREAK_RX;
                  end
               end else begin
                  sample_cnt_q <= sample_cnt_q + 1'b1;
               end
            end
            BREAK_RX: if (rx_s_q) begin
               state_q <= IDLE_RX;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE_RX;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.data        = data_q;
   assign bus.valid       = valid_q;
   assign bus.frame_error = ferr_q;
   assign bus.busy        = busy_q;

endmodule

// File: tb/tb_receiver.sv
// Scoreboard bench for the UART receiver at TICK_DIV=4 (64 clk per bit).
module tb_receiver;
   import receiver_pkg::*;

   typedef enum logic {EV_VALID, EV_FERR} ev_e;
   typedef struct packed {
      ev_e        kind;
      logic [7:0] data;
   } exp_t;

   localparam int BIT_CLK = 64;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   pulses = 0;
   exp_t exp_q[$];

   receiver_if bus ();

   receiver #(
      .TICK_DIV (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every output pulse is matched against the next queued expectation.
   always @(negedge clk) begin
      if (!rst && (bus.valid || bus.frame_error)) begin
         exp_t e;
         pulses++;
         check("valid_and_ferr_exclusive", 32'(bus.valid && bus.frame_error), 32'd0);
         if (exp_q.size() == 0) begin
            check("unexpected_pulse", {30'd0, bus.valid, bus.frame_error}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("pulse_kind_valid", 32'(bus.valid), 32'(e.kind == EV_VALID));
            check("pulse_data", 32'(bus.data), 32'(e.data));
            check("busy_at_pulse", 32'(bus.busy), 32'(e.kind == EV_FERR));
         end
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input int n, input logic stop);
      bus.rx = 1'b0;
      wait_clk(n);
      for (int i = 0; i < 8; i++) begin
         bus.rx = b[i];
         wait_clk(n);
      end
      bus.rx = stop;
      wait_clk(n);
   endtask

   task automatic idle_bits(input int bits);
      bus.rx = 1'b1;
      wait_clk(bits * BIT_CLK);
   endtask

   task automatic expect_byte(input logic [7:0] b);
      exp_q.push_back('{kind: EV_VALID, data: b});
   endtask

   initial begin
      int p0;
      int waited;
      logic [7:0] b;

      rst    = 1'b1;
      bus.rx = 1'b1;
      wait_clk(3);
      check("reset_data", 32'(bus.data), 32'h00);
      check("reset_valid", 32'(bus.valid), 32'd0);
      check("reset_ferr", 32'(bus.frame_error), 32'd0);
      check("reset_busy", 32'(bus.busy), 32'd0);
      rst = 1'b0;
      idle_bits(1);

      // Single byte, busy must be high mid-frame
      expect_byte(8'hA5);
      bus.rx = 1'b0;
      wait_clk(BIT_CLK);
      check("busy_mid_frame", 32'(bus.busy), 32'd1);
      for (int i = 0; i < 8; i++) begin
         b = 8'hA5;
         bus.rx = b[i];
         wait_clk(BIT_CLK);
      end
      bus.rx = 1'b1;
      wait_clk(BIT_CLK);
      idle_bits(2);

      // Back-to-back frames with no idle gap
      expect_byte(8'h01);
      expect_byte(8'h80);
      expect_byte(8'hFF);
      send_frame(8'h01, BIT_CLK, 1'b1);
      send_frame(8'h80, BIT_CLK, 1'b1);
      send_frame(8'hFF, BIT_CLK, 1'b1);
      idle_bits(2);

      // Glitch shorter than half a bit is rejected
      p0 = pulses;
      bus.rx = 1'b0;
      wait_clk(20);
      bus.rx = 1'b1;
      wait_clk(BIT_CLK);
      check("glitch_busy_idle", 32'(bus.busy), 32'd0);
      check("glitch_no_pulse", 32'(pulses), 32'(p0));
      expect_byte(8'h3C);
      send_frame(8'h3C, BIT_CLK, 1'b1);
      idle_bits(2);

      // Framing error followed by a held break
      exp_q.push_back('{kind: EV_FERR, data: 8'h3C});
      send_frame(8'h55, BIT_CLK, 1'b0);
      wait_clk(5 * BIT_CLK);
      check("break_busy_held", 32'(bus.busy), 32'd1);
      idle_bits(2);
      check("ferr_data_held", 32'(bus.data), 32'h3C);
      check("break_recovered", 32'(bus.busy), 32'd0);
      expect_byte(8'h12);
      send_frame(8'h12, BIT_CLK, 1'b1);
      idle_bits(2);

      // Reset during data bit 3 of 8'hC3
      p0 = pulses;
      b = 8'hC3;
      bus.rx = 1'b0;
      wait_clk(BIT_CLK);
      for (int i = 0; i < 3; i++) begin
         bus.rx = b[i];
         wait_clk(BIT_CLK);
      end
      bus.rx = b[3];
      wait_clk(BIT_CLK / 2);
      #2 rst = 1'b1;
      #1;
      check("midreset_data", 32'(bus.data), 32'h00);
      check("midreset_valid", 32'(bus.valid), 32'd0);
      check("midreset_ferr", 32'(bus.frame_error), 32'd0);
      check("midreset_busy", 32'(bus.busy), 32'd0);
      bus.rx = 1'b1;
      wait_clk(4);
      rst = 1'b0;
      idle_bits(1);
      check("midreset_no_pulse", 32'(pulses), 32'(p0));
      expect_byte(8'h7E);
      send_frame(8'h7E, BIT_CLK, 1'b1);
      idle_bits(2);

      // Bit-rate tolerance, fast and slow sender
      expect_byte(8'h96);
      send_frame(8'h96, 61, 1'b1);
      idle_bits(2);
      expect_byte(8'h96);
      send_frame(8'h96, 67, 1'b1);
      idle_bits(2);

      waited = 0;
      while (exp_q.size() != 0 && waited < 2000) begin
         @(negedge clk);
         waited++;
      end
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      check("total_pulses", 32'(pulses), 32'd10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
